// File: rtl/logic_pipe_pkg.sv
// Shared definitions for logic_pipe: operation encoding and completion-counter width.
package logic_pipe_pkg;

    // Operation select encoding carried on the 2-bit op port.
    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    // Width of the completed-transfer counter.
    localparam int unsigned DONE_CNT_W = 16;

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline stage of logic_pipe: a valid bit plus data register with
// ready/valid advance logic. The stage loads when it is empty or when its
// content is being taken by the downstream side in the same cycle.
module logic_pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_down_ready
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Ready depends only on local state and downstream readiness, never on i_valid.
    assign o_ready = !r_valid || i_down_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Valid/data register: reset wins; data only captured on an actual transfer in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: bitwise AND/OR/XOR/pass-A unit followed by a DEPTH-stage
// ready/valid pipeline, with a wrapping count of completed output transfers.
// Optional feature: define LOGIC_PIPE_PARITY_EN to add y_par (even parity of y),
// carried through the pipeline alongside the result.
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [1:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      y,
`ifdef LOGIC_PIPE_PARITY_EN
    output logic                  y_par,
`endif
    output logic [DONE_CNT_W-1:0] done_cnt
);

`ifdef LOGIC_PIPE_PARITY_EN
    localparam int unsigned DW = WIDTH + 1;
`else
    localparam int unsigned DW = WIDTH;
`endif

    logic [WIDTH-1:0]        w_result;
    logic [DEPTH:0]          w_valid;
    logic [DEPTH:0]          w_ready;
    logic [DEPTH:0][DW-1:0]  w_data;
    logic [DONE_CNT_W-1:0]   r_done_cnt;

    // Stage-0 operation; later stages only carry the registered result.
    always_comb begin
        w_result = '0;
        unique case (op_e'(op))
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_PASS: w_result = a;
        endcase
    end

    assign w_valid[0] = in_valid;
`ifdef LOGIC_PIPE_PARITY_EN
    assign w_data[0]  = {^w_result, w_result};
`else
    assign w_data[0]  = w_result;
`endif
    // Last stage's downstream is the output handshake.
    assign w_ready[DEPTH] = out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic_pipe_stage #(
            .DW (DW)
        ) u_stage (
            .clk          (clk),
            .reset        (reset),
            .i_valid      (w_valid[g]),
            .i_data       (w_data[g]),
            .o_ready      (w_ready[g]),
            .o_valid      (w_valid[g+1]),
            .o_data       (w_data[g+1]),
            .i_down_ready (w_ready[g+1])
        );
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[DEPTH];
    assign y         = w_data[DEPTH][WIDTH-1:0];
`ifdef LOGIC_PIPE_PARITY_EN
    assign y_par     = w_data[DEPTH][WIDTH];
`endif
    assign done_cnt  = r_done_cnt;

    // Count completed output transfers; wraps naturally at the counter width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// Directed self-checking bench for logic_pipe (WIDTH=8, DEPTH=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_logic_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [15:0]      done_cnt;
`ifdef LOGIC_PIPE_PARITY_EN
    logic             y_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
`ifdef LOGIC_PIPE_PARITY_EN
        .y_par     (y_par),
`endif
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operand set through an otherwise empty pipe with out_ready=1.
    task automatic send_one(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] top,
                            input logic [7:0] exp_y, input logic exp_par);
        @(negedge clk);
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        check("lat_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0; a = 8'hAA; b = 8'h55; op = 2'b00;
        @(negedge clk);
        check("lat_ov_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check("lat_ov_cycle2", out_valid, 1'b1);
        check("lat_y", y, exp_y);
`ifdef LOGIC_PIPE_PARITY_EN
        check("lat_y_par", y_par, exp_par);
`else
        if (exp_par !== (^exp_y)) $display("note: parity vector inconsistent");
`endif
        @(negedge clk);
        check("lat_ov_after", out_valid, 1'b0);
    endtask

    initial begin
        int k;
        int n;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_done_cnt", done_cnt, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);

        // Latency and operations
        out_ready = 1'b1;
        send_one(8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0);
        send_one(8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0);
        send_one(8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0);
        send_one(8'hF0, 8'h3C, 2'b11, 8'hF0, 1'b0);
        send_one(8'h07, 8'h00, 2'b11, 8'h07, 1'b1);
        send_one(8'h03, 8'hFF, 2'b11, 8'h03, 1'b0);
        check("lat_done_cnt", done_cnt, 16'd6);

        // Backpressure: two sets fit, third is refused
        @(negedge clk);
        out_ready = 1'b0;
        a = 8'h11; b = 8'h00; op = 2'b11; in_valid = 1'b1;
        check("bp_ready_1", in_ready, 1'b1);
        @(posedge clk);
        #1 a = 8'h22;
        @(negedge clk);
        check("bp_ready_2", in_ready, 1'b1);
        @(posedge clk);
        #1 a = 8'h33;
        @(negedge clk);
        check("bp_ready_3", in_ready, 1'b0);
        check("bp_ov_stall", out_valid, 1'b1);
        check("bp_y_stall", y, 8'h11);
        @(negedge clk);
        check("bp_ready_3b", in_ready, 1'b0);
        check("bp_y_stable", y, 8'h11);
        check("bp_ov_stable", out_valid, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ov_second", out_valid, 1'b1);
        check("bp_y_second", y, 8'h22);
        @(negedge clk);
        check("bp_ov_empty", out_valid, 1'b0);
        check("bp_done_cnt", done_cnt, 16'd8);

        // Throughput: 100 cycles of continuous traffic, pass-A with counting data
        k = 0;
        op = 2'b11; b = 8'h00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i >= 2) check("tp_no_bubble", out_valid, 1'b1);
            else        check("tp_fill", out_valid, 1'b0);
            if (out_valid) begin
                check("tp_order", y, k[7:0]);
                k++;
            end
            check("tp_in_ready", in_ready, 1'b1);
            a = i[7:0]; in_valid = 1'b1;
        end
        @(negedge clk);
        check("tp_count", k, 98);
        check("tp_done_cnt", done_cnt, 16'd106);

        // Mid-operation reset with two results in flight
        check("mr_in_flight", out_valid, 1'b1);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_done_cnt", done_cnt, 16'h0000);
        check("mr_in_ready", in_ready, 1'b1);
        @(negedge clk);
        check("mr_no_stale", out_valid, 1'b0);

        // Counter wrap: 65537 transfers
        a = 8'h5A; op = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 70000 && n < 65537; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        check("wrap_transfers", n, 65537);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("wrap_done_cnt", done_cnt, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
